// File: rtl/hex_count_display.sv
// Multi-digit hex/decimal up/down counter with prescaler and registered active-low
// seven-segment drive. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module hex_count_display #(
   parameter int NDIG     = 4,
   parameter int PRESCALE = 1
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              En,
   input  logic              Up,
   input  logic              Mode,
   input  logic              Load,
   input  logic [4*NDIG-1:0] LoadVal,
   output logic [4*NDIG-1:0] Count,
   output logic              Wrap,
   output logic [7*NDIG-1:0] HEX
);

   localparam int CW = 4 * NDIG;
   localparam int HW = 7 * NDIG;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // Walk from the top digit down; blanking stops at the first non-zero digit.
   function automatic logic [HW-1:0] render(input logic [CW-1:0] c);
      logic [HW-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
      logic lead;
      lead = 1'b1;
`endif
      r = '0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         r[7*i +: 7] = glyph(c[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
         if (lead && i != 0 && c[4*i +: 4] == 4'h0) r[7*i +: 7] = 7'b1111111;
         else lead = 1'b0;
`endif
      end
      return r;
   endfunction

   localparam logic [HW-1:0] HEX_RST = render('0);

   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] p_q, p_d;
   logic          wrap_q, wrap_d;
   logic [HW-1:0] hex_q, hex_d;
   logic          tick;

   always_comb begin
      logic       carry;
      logic [3:0] d;
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      count_d = count_q;
      p_d     = p_q;
      wrap_d  = 1'b0;
      carry   = 1'b0;
      d       = 4'h0;
      tick    = En && (p_q == P_LAST);
      hex_d   = render(count_q);

      if (Load) begin
         count_d = LoadVal;
         p_d     = '0;
      end else if (En) begin
         p_d = tick ? '0 : p_q + 1'b1;
         if (tick) begin
            carry = 1'b1;
            for (int i = 0; i < NDIG; i++) begin
               d = count_q[4*i +: 4];
               if (carry) begin
                  if (Up) begin
                     if (d == 4'hF || (Mode && d >= 4'd9)) count_d[4*i +: 4] = 4'h0;
                     else begin
                        count_d[4*i +: 4] = d + 4'd1;
                        carry = 1'b0;
                     end
                  end else if (Mode && d > 4'd9) begin
                     // Out-of-range decimal digit settles to 9 without borrowing.
                     count_d[4*i +: 4] = 4'd9;
                     carry = 1'b0;
                  end else if (d == 4'h0) begin
                     count_d[4*i +: 4] = Mode ? 4'd9 : 4'hF;
                  end else begin
                     count_d[4*i +: 4] = d - 4'd1;
                     carry = 1'b0;
                  end
               end
            end
            wrap_d = carry;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         count_q <= '0;
         p_q     <= '0;
         wrap_q  <= 1'b0;
         hex_q   <= HEX_RST;
      end else begin
         count_q <= count_d;
         p_q     <= p_d;
         wrap_q  <= wrap_d;
         hex_q   <= hex_d;
      end
   end

   assign Count = count_q;
   assign Wrap  = wrap_q;
   assign HEX   = hex_q;

endmodule
